ce_rate_meter: RTL

Closed-loop check on the simulation clock-enable. The block counts `sim_ce` pulses over a fixed gate window of `GATE_CYCLES` system clocks and reports the measured rate in Hz. It also reports whether that rate lies within a tolerance of the programmed target. It sits beside the clock divider on the same `clk`/`rst_n` domain. Its input is the divider's `sim_ce` output, and its results feed the status/debug readout.

---
 rtl/sim_clk_pkg.sv | 13 +
 rtl/ce_rate_meter_if.sv | 24 ++
 rtl/sat_counter.sv | 30 +++
 rtl/ce_rate_meter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/sim_clk_pkg.sv
// Shared definitions for the simulation clock-enable blocks (divider and rate meter).
package sim_clk_pkg;
  localparam int unsigned INPUT_FREQ_DEFAULT = 25_000_000;
  localparam int unsigned CE_HZ_W            = 12;
  localparam int unsigned TOL_W              = 8;
  localparam int unsigned CNT_W              = CE_HZ_W + 1;
  localparam int unsigned CNT_LIMIT          = 1 << CE_HZ_W;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_e;
endpackage

// File: rtl/ce_rate_meter_if.sv
// Control and result signals of the clock-enable rate meter.
interface ce_rate_meter_if;
  import sim_clk_pkg::*;

  logic               ce_in;
  logic               enable;
  logic [CE_HZ_W-1:0] target_x_hz;
  logic [TOL_W-1:0]   tolerance;
  logic [CE_HZ_W-1:0] measured_hz;
  logic               saturated;
  logic               in_tol;
  logic               meas_valid;
  logic               busy;

  modport master (
    output ce_in, enable, target_x_hz, tolerance,
    input  measured_hz, saturated, in_tol, meas_valid, busy
  );

  modport slave (
    input  ce_in, enable, target_x_hz, tolerance,
    output measured_hz, saturated, in_tol, meas_valid, busy
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; exposes the count including this cycle's increment.
module sat_counter #(
  parameter int unsigned W     = 13,
  parameter int unsigned LIMIT = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_total_c
);
  logic [W-1:0] r_count;

  always_comb begin
    o_total_c = r_count;
    if (i_inc && (r_count < W'(LIMIT))) begin
      o_total_c = r_count + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else begin
      r_count <= o_total_c;
    end
  end
endmodule

// File: rtl/ce_rate_meter.sv
// Counts ce_in pulses over back-to-back gate windows and reports rate, saturation and
// whether the rate lies within tolerance of the programmed target.
module ce_rate_meter
  import sim_clk_pkg::*;
#(
  parameter int unsigned INPUT_FREQ  = INPUT_FREQ_DEFAULT,
  parameter int unsigned GATE_CYCLES = INPUT_FREQ
) (
  input logic            clk,
  input logic            rst_n,
  ce_rate_meter_if.slave bus
);
  localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  meter_state_e              r_state;
  meter_state_e              w_state_nxt;
  logic [GATE_W-1:0]         r_gate;
  logic                      w_final;
  logic                      w_cnt_clr;
  logic [CNT_W-1:0]          w_total;
  logic                      w_sat;
  logic [CE_HZ_W-1:0]        w_meas_hz;
  logic signed [CNT_W-1:0]   w_diff;
  logic [CNT_W-1:0]          w_abs;
  logic                      w_in_tol;

  logic [CE_HZ_W-1:0]        r_measured_hz;
  logic                      r_saturated;
  logic                      r_in_tol;
  logic                      r_meas_valid;
  logic                      r_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The enabling cycle in IDLE is window cycle 0; clearing counters on the final cycle
  // makes the next cycle window cycle 0 with no dead cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_final     = 1'b0;
    w_cnt_clr   = 1'b1;
    case (r_state)
      IDLE: begin
        if (bus.enable) begin
          w_state_nxt = MEASURE;
          w_cnt_clr   = 1'b0;
        end
      end
      MEASURE: begin
        if (!bus.enable) begin
          w_state_nxt = IDLE;
        end else begin
          w_final   = (r_gate == GATE_LAST);
          w_cnt_clr = w_final;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gate <= '0;
    end else if (w_cnt_clr) begin
      r_gate <= '0;
    end else begin
      r_gate <= r_gate + GATE_W'(1);
    end
  end

  sat_counter #(
    .W     (CNT_W),
    .LIMIT (CNT_LIMIT)
  ) u_pulse_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_cnt_clr),
    .i_inc     (bus.ce_in),
    .o_total_c (w_total)
  );

  // Result of the window ending this cycle, including this cycle's pulse.
  always_comb begin
    w_sat     = (w_total >= CNT_W'(CNT_LIMIT));
    w_meas_hz = w_sat ? '1 : w_total[CE_HZ_W-1:0];
    w_diff    = $signed({1'b0, w_meas_hz}) - $signed({1'b0, bus.target_x_hz});
    w_abs     = w_diff[CNT_W-1] ? $unsigned(-w_diff) : $unsigned(w_diff);
    w_in_tol  = !w_sat && (w_abs <= CNT_W'(bus.tolerance));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_measured_hz <= '0;
      r_saturated   <= 1'b0;
      r_in_tol      <= 1'b0;
      r_meas_valid  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_meas_valid <= w_final;
      r_busy       <= (w_state_nxt == MEASURE);
      if (w_final) begin
        r_measured_hz <= w_meas_hz;
        r_saturated   <= w_sat;
        r_in_tol      <= w_in_tol;
      end
    end
  end

  assign bus.measured_hz = r_measured_hz;
  assign bus.saturated   = r_saturated;
  assign bus.in_tol      = r_in_tol;
  assign bus.meas_valid  = r_meas_valid;
  assign bus.busy        = r_busy;
endmodule
